// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: bus codes,
// the nop used for faulted entries, and the fetch control states.
package fetch_pkg;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  SIZE_W    = 2'b10;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DISCARD,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush. DEPTH must be a power of two so the
// pointers wrap naturally; flush clears occupancy and wins over push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; readers qualify it with o_empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, queues
// {fault, pc, inst} for decode, and flushes/restarts on redirect.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_ready,
  input  logic [1:0]             if_resp,
  input  logic [XLEN-1:0]        if_data_read,
  output logic                   if_valid,
  output logic [XLEN-1:0]        if_addr,
  output logic [1:0]             if_size,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_fault,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned EW = 1 + XLEN + 32;

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  w_fetch_pc_nxt;
  logic [XLEN-1:0]  r_req_addr;
  logic [XLEN-1:0]  w_req_addr_nxt;
  logic             r_run;
  logic             w_req;
  logic             w_push;
  logic             w_fault;
  logic [31:0]      w_inst;
  logic [XLEN-1:0]  w_redir_pc;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_rdata;
  logic             w_full;
  logic             w_empty;

  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_fault    = (if_resp != RESP_OKAY);
  assign w_inst     = w_fault ? NOP_INST
                    : (r_fetch_pc[2] ? if_data_read[XLEN-1 -: 32] : if_data_read[31:0]);
  assign w_wdata    = {w_fault, r_fetch_pc, w_inst};

  // r_run keeps the request low while reset is asserted; issue only needs
  // count<DEPTH because at most one request is ever outstanding.
  assign w_req    = r_run & (((r_state == ST_FETCH) & ~w_full) | (r_state == ST_DISCARD));
  assign if_valid = w_req;
  assign if_addr  = (r_state == ST_DISCARD) ? r_req_addr : r_fetch_pc;
  assign if_size  = SIZE_W;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_push         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = w_redir_pc;
          if (w_req && !if_ready) begin
            w_state_nxt    = ST_DISCARD;
            w_req_addr_nxt = r_fetch_pc;
          end
        end else if (w_req && if_ready) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
          if (w_fault) w_state_nxt = ST_HALT;
        end
      end
      ST_DISCARD: begin
        if (redirect_valid) w_fetch_pc_nxt = w_redir_pc;
        if (if_ready) w_state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = w_redir_pc;
          w_state_nxt    = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_run      <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (out_valid & out_ready),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign out_valid = ~w_empty;
  assign out_inst  = w_empty ? '0 : w_rdata[31:0];
  assign out_pc    = w_empty ? '0 : w_rdata[XLEN+31:32];
  assign out_fault = w_empty ? 1'b0 : w_rdata[EW-1];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scenario bench for if_fetch_queue: expected entries are queued when the
// bench completes a fetch and compared when decode sees them.
module tb_if_fetch_queue;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic [1:0]  if_resp;
  logic [63:0] if_data_read;
  logic        if_valid;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } ent_t;

  ent_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_pc;

  if_fetch_queue #(
    .XLEN     (64),
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_ready       (if_ready),
    .if_resp        (if_resp),
    .if_data_read   (if_data_read),
    .if_valid       (if_valid),
    .if_addr        (if_addr),
    .if_size        (if_size),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .count          (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mkdata(input logic [63:0] a);
    return {32'hB000_0000 ^ a[31:0], 32'hA000_0000 ^ a[31:0]};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] a);
    logic [63:0] d;
    d = mkdata(a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic idle_inputs();
    if_ready       = 1'b0;
    if_resp        = 2'b00;
    if_data_read   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
  endtask

  // Leaves the bench just after a negedge with the DUT out of reset.
  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    sb.delete();
    exp_pc = RST_PC;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_addr !== RST_PC) begin failures++; $display("FAIL rst_if_addr got=%h exp=%h", if_addr, RST_PC); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL rst_out_inst got=%h exp=0", out_inst); end
    checks++; if (out_pc !== 64'h0) begin failures++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_fault !== 1'b0) begin failures++; $display("FAIL rst_out_fault got=%b exp=0", out_fault); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (if_size !== 2'b10) begin failures++; $display("FAIL rst_if_size got=%b exp=10", if_size); end
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL rst_first_req got=%b exp=1", if_valid); end
    checks++; if (if_addr !== RST_PC) begin failures++; $display("FAIL rst_first_addr got=%h exp=%h", if_addr, RST_PC); end
  endtask

  task automatic test_stream();
    int   fetched = 0;
    int   cyc     = 0;
    ent_t e;
    reset_dut();
    out_ready = 1'b1;
    while ((fetched < 3 || sb.size() != 0) && cyc < 40) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL stream_extra got_pc=%h exp=none", out_pc);
        end else begin
          e = sb.pop_front();
          if (out_inst !== e.inst || out_pc !== e.pc || out_fault !== e.fault) begin
            failures++;
            $display("FAIL stream_entry got=%h/%h/%b exp=%h/%h/%b", out_inst, out_pc, out_fault, e.inst, e.pc, e.fault);
          end
        end
      end
      if (if_valid && fetched < 3) begin
        checks++;
        if (if_addr !== exp_pc) begin failures++; $display("FAIL stream_addr got=%h exp=%h", if_addr, exp_pc); end
        sb.push_back('{exp_inst(exp_pc), exp_pc, 1'b0});
        if_data_read = mkdata(exp_pc);
        if_ready     = 1'b1;
        exp_pc       = exp_pc + 64'd4;
        fetched++;
      end else begin
        if_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 40) begin failures++; $display("FAIL stream_timeout got=%0d exp=<40", cyc); end
  endtask

  task automatic test_full();
    int   fetched = 0;
    ent_t e;
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      if (if_valid) begin
        sb.push_back('{exp_inst(exp_pc), exp_pc, 1'b0});
        if_data_read = mkdata(exp_pc);
        if_ready     = 1'b1;
        exp_pc       = exp_pc + 64'd4;
        fetched++;
      end else begin
        if_ready = 1'b0;
      end
      @(negedge clk);
    end
    if_ready = 1'b0;
    checks++; if (fetched != 4) begin failures++; $display("FAIL full_fetches got=%0d exp=4", fetched); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL full_if_valid got=%b exp=0", if_valid); end
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== e.pc || out_inst !== e.inst) begin
      failures++; $display("FAIL full_head got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_inst, e.pc, e.inst);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_pop_count got=%0d exp=3", count); end
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL full_reissue got=%b exp=1", if_valid); end
    checks++; if (if_addr !== exp_pc) begin failures++; $display("FAIL full_reissue_addr got=%h exp=%h", if_addr, exp_pc); end
    checks++; if (out_pc !== sb[0].pc) begin failures++; $display("FAIL full_next_head got=%h exp=%h", out_pc, sb[0].pc); end
  endtask

  task automatic test_redirect_pending();
    reset_dut();
    if_data_read = mkdata(RST_PC);
    if_ready     = 1'b1;
    @(negedge clk);
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL rp_count1 got=%0d exp=1", count); end
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (if_valid !== 1'b1 || if_addr !== 64'h8000_0004) begin
        failures++; $display("FAIL rp_hold got=%b/%h exp=1/%h", if_valid, if_addr, 64'h8000_0004);
      end
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
        failures++; $display("FAIL rp_flushed got=%b/%0d exp=0/0", out_valid, count);
      end
      if_ready     = (c == 2);
      if_data_read = mkdata(64'h8000_0004);
      @(negedge clk);
    end
    if_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rp_dropped got=%b exp=0", out_valid); end
    checks++;
    if (if_valid !== 1'b1 || if_addr !== 64'h8000_0100) begin
      failures++; $display("FAIL rp_new_addr got=%b/%h exp=1/%h", if_valid, if_addr, 64'h8000_0100);
    end
    if_data_read = mkdata(64'h8000_0100);
    if_ready     = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100 || out_inst !== exp_inst(64'h8000_0100)) begin
      failures++; $display("FAIL rp_new_entry got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_inst, 64'h8000_0100, exp_inst(64'h8000_0100));
    end
  endtask

  task automatic test_redirect_completion();
    reset_dut();
    out_ready    = 1'b1;
    if_data_read = mkdata(RST_PC);
    if_ready     = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RST_PC || out_inst !== exp_inst(RST_PC)) begin
      failures++; $display("FAIL rc_first got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_inst, RST_PC, exp_inst(RST_PC));
    end
    if_data_read   = mkdata(64'h8000_0004);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    out_ready      = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL rc_empty got=%b/%0d exp=0/0", out_valid, count);
    end
    checks++;
    if (if_valid !== 1'b1 || if_addr !== 64'h8000_0200) begin
      failures++; $display("FAIL rc_addr got=%b/%h exp=1/%h", if_valid, if_addr, 64'h8000_0200);
    end
  endtask

  task automatic test_fault();
    ent_t e;
    int   cyc = 0;
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (if_valid !== 1'b1 || if_addr !== exp_pc) begin
        failures++; $display("FAIL flt_req got=%b/%h exp=1/%h", if_valid, if_addr, exp_pc);
      end
      if_resp      = (c == 2) ? 2'b10 : 2'b00;
      if_data_read = mkdata(exp_pc);
      if_ready     = 1'b1;
      sb.push_back('{(c == 2) ? 32'h0000_0013 : exp_inst(exp_pc), exp_pc, (c == 2)});
      exp_pc = exp_pc + 64'd4;
      @(negedge clk);
    end
    if_ready = 1'b0;
    if_resp  = 2'b00;
    for (int c = 0; c < 3; c++) begin
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL flt_halt got=%b exp=0", if_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    while (sb.size() != 0 && cyc < 10) begin
      if (out_valid) begin
        e = sb.pop_front();
        checks++;
        if (out_inst !== e.inst || out_pc !== e.pc || out_fault !== e.fault) begin
          failures++;
          $display("FAIL flt_entry got=%h/%h/%b exp=%h/%h/%b", out_inst, out_pc, out_fault, e.inst, e.pc, e.fault);
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (cyc >= 10) begin failures++; $display("FAIL flt_drain_timeout got=%0d exp=<10", cyc); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL flt_still_halt got=%b exp=0", if_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_addr !== 64'h8000_0300) begin
      failures++; $display("FAIL flt_resume got=%b/%h exp=1/%h", if_valid, if_addr, 64'h8000_0300);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    if_data_read = mkdata(RST_PC);
    if_ready     = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || if_valid !== 1'b1) begin
      failures++; $display("FAIL ar_busy got=%b/%b exp=1/1", out_valid, if_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL ar_cleared got=%b/%b/%0d exp=0/0/0", if_valid, out_valid, count);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_addr !== RST_PC) begin
      failures++; $display("FAIL ar_restart got=%b/%h exp=1/%h", if_valid, if_addr, RST_PC);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_full();
    test_redirect_pending();
    test_redirect_completion();
    test_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end that replaces the single-entry fetch path between the instruction bus and the IF/ID register. It issues sequential word fetches on the `if_*` bus, buffers up to DEPTH returned instructions with their PCs and fault status, and presents them to decode through a valid/ready handshake. A redirect, from a branch/jump resolved in MEM or from an exception/trap target, flushes the queue. A bus transaction already in flight at redirect time is allowed to complete, and its data is discarded.

## Interface
- `XLEN`, 64: address/data width of the fetch bus and PC.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 64'h8000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_ready`  in  1  bus completes the current request this cycle; `if_data_read`/`if_resp` valid.
- `if_resp`  in  2  response code: 2'b00 OKAY, any other value is an access fault.
- `if_data_read`  in  XLEN  returned doubleword.
- `if_valid`  out  1  request pending.
- `if_addr`  out  XLEN  request address (word-aligned).
- `if_size`  out  2  constant 2'b10 (word).
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  decode accepts head entry.
- `out_inst`  out  32  head instruction.
- `out_pc`  out  XLEN  head PC.
- `out_fault`  out  1  head entry carries an access fault; `out_inst` is 32'h0000_0013 (nop).
- `count`  out  $clog2(DEPTH)+1  occupied entries (debug/perf).

## Operation
- Single outstanding request. States: FETCH, DISCARD, HALT.
- FETCH: `if_valid`=1 when count<DEPTH. `if_addr` is held at `fetch_pc`. Once asserted, `if_valid` and `if_addr` stay stable until `if_ready`. They are never retracted, even on redirect.
- Completion (`if_valid & if_ready`) in FETCH:
  - Push {inst, pc=`fetch_pc`, fault}. inst = `if_data_read[63:32]` if `fetch_pc[2]`, else `[31:0]`.
  - fetch_pc += 4 (wraps modulo 2^XLEN).
  - If fault, go to HALT.
- HALT: `if_valid`=0 until redirect. The faulting entry still drains normally.
- Redirect while a request is outstanding (`if_valid & ~if_ready`): flush the queue, set fetch_pc=`redirect_pc`, go to DISCARD. DISCARD keeps the old request asserted. Its completion is dropped (no push), then the block returns to FETCH.
- Redirect in the same cycle as a completion: the completion is dropped, the queue is flushed, and the block enters FETCH at `redirect_pc`.
- Redirect in any other state or cycle: flush, fetch_pc=`redirect_pc`, enter FETCH.
- Pop on `out_valid & out_ready`. Pop and push in the same cycle are allowed; count is unchanged.
- Redirect takes priority over pop and push in that cycle. The queue is empty next cycle.
- Full (count==DEPTH): no new request is issued. An in-flight request cannot exist when full, because issue requires count<DEPTH and there is only one outstanding.

## Timing
- Reset values: `if_valid`=0, `if_addr`=`RESET_PC`, `out_valid`=0, `out_inst`=0, `out_pc`=0, `out_fault`=0, `count`=0, state=FETCH.
- First `if_valid` is asserted in the first cycle after `rst` deasserts.
- Completion at cycle t: entry is visible on `out_*` at t+1 (registered, no bypass). The next request is issued at t+1.
- Redirect at cycle t with no request outstanding: `if_valid` with `redirect_pc` at t+1, `out_valid`=0 at t+1.
- Redirect at cycle t during DISCARD: only fetch_pc is updated; the latest redirect wins.
- Reset asserted mid-transaction: all state is cleared immediately and the bus request is abandoned.

## Structure
- Shared package `fetch_pkg`: resp codes (RESP_OKAY=2'b00), size codes (SIZE_W=2'b10), NOP_INST, fetch-state enum.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; push/pop/flush, full/empty/count) holds {fault, pc, inst}. Control FSM and PC logic live in the top.

## Test plan
- Reset release: fetches issued at 0x8000_0000, 0x8000_0004, 0x8000_0008 with 1-cycle `if_ready`. Decode sees insts from data[31:0], data[63:32], data[31:0] in order, with matching PCs.
- `out_ready`=0 with DEPTH=4: exactly 4 entries fill, `count`=4, `if_valid` stays 0. One pop leads to a new request next cycle.
- Redirect to 0x8000_0100 while a request waits 3 cycles for `if_ready`: old `if_addr` is held, its data never appears on `out_*`, and the next request is 0x8000_0100.
- Redirect in the same cycle as a completion and a pop: queue empty next cycle, `out_valid`=0, next `if_addr`=`redirect_pc`.
- `if_resp`=2'b10 on 0x8000_0008: entry has `out_fault`=1 and `out_inst`=0x13, no further requests are issued, and a redirect resumes fetching.
- Async `rst` low mid-request: `if_valid` and `out_valid` drop immediately, and fetch restarts at `RESET_PC`.
